// File: rtl/lpddr4_ctrl_pkg.sv
// Shared types and constants for the two-port lpddr4 controller.
package lpddr4_ctrl_pkg;

    localparam int unsigned NUM_PORTS   = 2;
    localparam int unsigned BYTE_ADDR_W = 32;
    localparam int unsigned WORD_LSB    = 2;
    localparam int unsigned BANK_LSB    = 16;
    localparam int unsigned RANGE_LSB   = 19;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_CMD  = 3'd1,
        S_RD_DATA = 3'd2,
        S_MERGE   = 3'd3,
        S_WR_CMD  = 3'd4,
        S_RESP    = 3'd5
    } state_t;

    // Active-low command pin bundle, order {cs, ras, cas, we}
    typedef struct packed {
        logic cs;
        logic ras;
        logic cas;
        logic we;
    } cmd_t;

    localparam cmd_t CMD_NOP = 4'b1111;
    localparam cmd_t CMD_RD  = 4'b0001;
    localparam cmd_t CMD_WR  = 4'b0000;

    // Any byte-address bit above the bank field means the access is unmapped
    function automatic logic out_of_range(input logic [BYTE_ADDR_W-1:0] a);
        return |a[BYTE_ADDR_W-1:RANGE_LSB];
    endfunction

endpackage

// File: rtl/lpddr4_ctrl_rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer remembers the last granted port.
module rr_arbiter2
    import lpddr4_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant_c,
    output logic       idx_c
);

    logic last_q;

    // Grant the lone requester, or the port that did not win last time
    always_comb begin
        grant_c = 2'b00;
        idx_c   = 1'b0;
        case (req)
            2'b01: begin
                grant_c = 2'b01;
                idx_c   = 1'b0;
            end
            2'b10: begin
                grant_c = 2'b10;
                idx_c   = 1'b1;
            end
            2'b11: begin
                idx_c   = ~last_q;
                grant_c = last_q ? 2'b01 : 2'b10;
            end
            default: begin
                grant_c = 2'b00;
                idx_c   = 1'b0;
            end
        endcase
    end

    // Pointer starts at port 1 so port 0 wins the first contested grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (update) begin
            last_q <= idx_c;
        end
    end

endmodule

// File: rtl/lpddr4_ctrl.sv
// Two-port lpddr4 controller: round-robin arbitration, one access in flight,
// read-modify-write for partial-strobe writes.
module lpddr4_ctrl
    import lpddr4_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned BA_W   = 3,
    parameter int unsigned DATA_W = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_PORTS-1:0]             req_valid,
    output logic [NUM_PORTS-1:0]             req_ready,
    input  logic [NUM_PORTS-1:0]             req_we,
    input  logic [NUM_PORTS*BYTE_ADDR_W-1:0] req_addr,
    input  logic [NUM_PORTS*DATA_W-1:0]      req_wdata,
    input  logic [NUM_PORTS*(DATA_W/8)-1:0]  req_wstrb,
    output logic [NUM_PORTS-1:0]             resp_valid,
    output logic [DATA_W-1:0]                resp_rdata,
    output logic                             resp_err,
    output logic                             mem_cs,
    output logic                             mem_ras,
    output logic                             mem_cas,
    output logic                             mem_we,
    output logic [ADDR_W-1:0]                mem_addr,
    output logic [BA_W-1:0]                  mem_ba,
    inout  wire  [DATA_W-1:0]                mem_dq,
    output logic [DATA_W/8-1:0]              mem_dm,
    output logic                             mem_dqs
);

    localparam int unsigned STRB_W = DATA_W / 8;

    state_t              state;
    cmd_t                cmd_q;
    logic                port_q;
    logic                we_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                dq_oe_q;
    logic                dqs_q;

    logic [BYTE_ADDR_W-1:0] addr_arr  [NUM_PORTS];
    logic [DATA_W-1:0]      wdata_arr [NUM_PORTS];
    logic [STRB_W-1:0]      wstrb_arr [NUM_PORTS];

    logic [1:0]             grant_c;
    logic                   gnt_idx_c;
    logic                   accept_c;
    logic [BYTE_ADDR_W-1:0] sel_addr_c;
    logic [DATA_W-1:0]      sel_wdata_c;
    logic [STRB_W-1:0]      sel_wstrb_c;
    logic                   sel_we_c;
    logic [DATA_W-1:0]      merged_c;
    logic                   unused_addr_bits;

    // Split the flat per-port request buses into indexable arrays
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            addr_arr[p]  = req_addr[p*BYTE_ADDR_W +: BYTE_ADDR_W];
            wdata_arr[p] = req_wdata[p*DATA_W +: DATA_W];
            wstrb_arr[p] = req_wstrb[p*STRB_W +: STRB_W];
        end
    end

    assign accept_c    = (state == S_IDLE) && (|req_valid);
    assign sel_addr_c  = addr_arr[gnt_idx_c];
    assign sel_wdata_c = wdata_arr[gnt_idx_c];
    assign sel_wstrb_c = wstrb_arr[gnt_idx_c];
    assign sel_we_c    = req_we[gnt_idx_c];

    // Byte offset within the word is not used by a word-wide memory
    assign unused_addr_bits = ^sel_addr_c[WORD_LSB-1:0];

    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .update  (accept_c),
        .grant_c (grant_c),
        .idx_c   (gnt_idx_c)
    );

    // Ready is only offered while idle, so a busy access makes requesters wait
    assign req_ready = (state == S_IDLE) ? grant_c : 2'b00;

    // Byte merge of new write data over the word just read back
    always_comb begin
        merged_c = rdata_q;
        for (int i = 0; i < STRB_W; i++) begin
            merged_c[8*i +: 8] = wstrb_q[i] ? wdata_q[8*i +: 8] : rdata_q[8*i +: 8];
        end
    end

    assign mem_cs  = cmd_q.cs;
    assign mem_ras = cmd_q.ras;
    assign mem_cas = cmd_q.cas;
    assign mem_we  = cmd_q.we;
    assign mem_dqs = dqs_q;
    assign mem_dm  = '0;
    assign mem_dq  = dq_oe_q ? wdata_q : {DATA_W{1'bz}};

    // Access sequencer; pin registers are loaded together with the state they belong to
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cmd_q      <= CMD_NOP;
            port_q     <= 1'b0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            rdata_q    <= '0;
            dq_oe_q    <= 1'b0;
            dqs_q      <= 1'b0;
            mem_addr   <= '0;
            mem_ba     <= '0;
            resp_valid <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= '0;
            case (state)
                S_IDLE: begin
                    if (accept_c) begin
                        port_q   <= gnt_idx_c;
                        we_q     <= sel_we_c;
                        wdata_q  <= sel_wdata_c;
                        wstrb_q  <= sel_wstrb_c;
                        mem_addr <= sel_addr_c[WORD_LSB +: ADDR_W];
                        mem_ba   <= sel_addr_c[BANK_LSB +: BA_W];
                        if (out_of_range(sel_addr_c)) begin
                            state                 <= S_RESP;
                            resp_valid[gnt_idx_c] <= 1'b1;
                            resp_err              <= 1'b1;
                            resp_rdata            <= '0;
                        end else if (!sel_we_c || (sel_wstrb_c != {STRB_W{1'b1}})) begin
                            state <= S_RD_CMD;
                            cmd_q <= CMD_RD;
                        end else begin
                            state   <= S_WR_CMD;
                            cmd_q   <= CMD_WR;
                            dq_oe_q <= 1'b1;
                            dqs_q   <= 1'b1;
                        end
                    end
                end
                S_RD_CMD: begin
                    state <= S_RD_DATA;
                    cmd_q <= CMD_NOP;
                end
                S_RD_DATA: begin
                    rdata_q <= mem_dq;
                    if (we_q) begin
                        state <= S_MERGE;
                    end else begin
                        state              <= S_RESP;
                        resp_valid[port_q] <= 1'b1;
                        resp_rdata         <= mem_dq;
                        resp_err           <= 1'b0;
                    end
                end
                S_MERGE: begin
                    wdata_q <= merged_c;
                    state   <= S_WR_CMD;
                    cmd_q   <= CMD_WR;
                    dq_oe_q <= 1'b1;
                    dqs_q   <= 1'b1;
                end
                S_WR_CMD: begin
                    state              <= S_RESP;
                    cmd_q              <= CMD_NOP;
                    dq_oe_q            <= 1'b0;
                    dqs_q              <= 1'b0;
                    resp_valid[port_q] <= 1'b1;
                    resp_rdata         <= '0;
                    resp_err           <= 1'b0;
                end
                S_RESP: begin
                    state      <= S_IDLE;
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                end
                default: begin
                    state   <= S_IDLE;
                    cmd_q   <= CMD_NOP;
                    dq_oe_q <= 1'b0;
                    dqs_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lpddr4_ctrl.sv
// Self-checking bench for lpddr4_ctrl with a simple lpddr4 memory model.
module tb_lpddr4_ctrl;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_we;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wstrb;
    logic [1:0]  resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_cs, mem_ras, mem_cas, mem_we;
    logic [13:0] mem_addr;
    logic [2:0]  mem_ba;
    wire  [31:0] mem_dq;
    logic [3:0]  mem_dm;
    logic        mem_dqs;

    int n_pass  = 0;
    int n_total = 0;

    lpddr4_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_cs(mem_cs), .mem_ras(mem_ras), .mem_cas(mem_cas), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_ba(mem_ba), .mem_dq(mem_dq), .mem_dm(mem_dm),
        .mem_dqs(mem_dqs)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- memory model ----------------
    logic [31:0] mem_arr [logic [16:0]];
    logic        tb_oe;
    logic [31:0] tb_dq;
    int          rd_cmds = 0;
    int          wr_cmds = 0;
    int          cs_low  = 0;
    int          resp_pulses = 0;
    int          bus_clash = 0;

    assign mem_dq = tb_oe ? tb_dq : 32'bz;

    always @(posedge clk) begin
        if (rst) begin
            tb_oe <= 1'b0;
        end else begin
            tb_oe <= 1'b0;
            if (!mem_cs) cs_low++;
            if (!mem_cs && !mem_ras && !mem_cas) begin
                if (mem_we) begin
                    rd_cmds++;
                    tb_oe <= 1'b1;
                    tb_dq <= mem_arr.exists({mem_ba, mem_addr}) ? mem_arr[{mem_ba, mem_addr}] : 32'h0;
                end else begin
                    wr_cmds++;
                    mem_arr[{mem_ba, mem_addr}] = mem_dq;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (|resp_valid) resp_pulses++;
        if (tb_oe && mem_dqs) bus_clash++;
    end

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [logic [16:0]];
    int          tb_last_port = 1;

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        mem_arr[a[18:2]] = d;
        ref_mem[a[18:2]] = d;
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        return ref_mem.exists(a[18:2]) ? ref_mem[a[18:2]] : 32'h0;
    endfunction

    // Expected outcome of one access, straight from the access rules
    task automatic ref_access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] strb, output logic [31:0] e_rdata,
                              output logic e_err, output int e_lat, output int e_rd,
                              output int e_wr);
        logic [31:0] old;
        e_rdata = 32'h0; e_err = 1'b0; e_rd = 0; e_wr = 0;
        if (a[31:19] != 13'h0) begin
            e_err = 1'b1; e_lat = 1;
        end else if (!we) begin
            e_rdata = ref_word(a); e_lat = 3; e_rd = 1;
        end else if (strb == 4'hF) begin
            ref_mem[a[18:2]] = wd; e_lat = 2; e_wr = 1;
        end else begin
            old = ref_word(a);
            for (int i = 0; i < 4; i++)
                if (strb[i]) old[8*i +: 8] = wd[8*i +: 8];
            ref_mem[a[18:2]] = old; e_lat = 5; e_rd = 1; e_wr = 1;
        end
    endtask

    function automatic logic [31:0] rand_addr();
        return {13'd0, 3'($urandom_range(0, 7)), 9'd0, 5'($urandom_range(0, 31)),
                2'($urandom_range(0, 3))};
    endfunction

    // ---------------- transaction driver ----------------
    task automatic run_txn(input int p, input logic we, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] strb,
                           output logic got, output int lat, output logic [1:0] rv,
                           output logic [31:0] rdata, output logic err,
                           output int nrd, output int nwr, output int ncs);
        int k, rd0, wr0, cs0;
        got = 1'b0; lat = 0; rv = 2'b00; rdata = 32'h0; err = 1'b0;
        nrd = 0; nwr = 0; ncs = 0;
        @(negedge clk);
        req_we[p] = we;
        req_addr[p*32 +: 32]  = a;
        req_wdata[p*32 +: 32] = wd;
        req_wstrb[p*4 +: 4]   = strb;
        req_valid[p] = 1'b1;
        #1;
        k = 0;
        while (!req_ready[p] && k < 50) begin
            @(negedge clk); #1; k++;
        end
        if (!req_ready[p]) begin
            req_valid[p] = 1'b0;
            n_total++;
            $display("FAIL accept_timeout port=%0d got no req_ready, required a grant", p);
            return;
        end
        rd0 = rd_cmds; wr0 = wr_cmds; cs0 = cs_low;
        @(posedge clk); #1;
        req_valid[p] = 1'b0;
        tb_last_port = p;
        k = 0;
        while (k < 20) begin
            @(negedge clk); #1; k++;
            if (|resp_valid) begin
                got = 1'b1; lat = k; rv = resp_valid; rdata = resp_rdata; err = resp_err;
                break;
            end
        end
        nrd = rd_cmds - rd0; nwr = wr_cmds - wr0; ncs = cs_low - cs0;
        if (!got) begin
            n_total++;
            $display("FAIL resp_timeout port=%0d addr=%h got no resp_valid within 20 cycles", p, a);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        req_valid = 2'b00; req_we = 2'b00; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        repeat (3) @(negedge clk);
        #1;
        n_total++;
        if ({mem_cs, mem_ras, mem_cas, mem_we} !== 4'b1111)
            $display("FAIL reset_cmd got=%b required=1111", {mem_cs, mem_ras, mem_cas, mem_we});
        else n_pass++;
        n_total++;
        if ({mem_dqs, mem_dm, mem_addr, mem_ba} !== '0)
            $display("FAIL reset_pins got dqs=%b dm=%h addr=%h ba=%h required all 0",
                     mem_dqs, mem_dm, mem_addr, mem_ba);
        else n_pass++;
        n_total++;
        if ({resp_valid, resp_rdata, resp_err, req_ready} !== '0)
            $display("FAIL reset_resp got rv=%b rdata=%h err=%b ready=%b required all 0",
                     resp_valid, resp_rdata, resp_err, req_ready);
        else n_pass++;
        rst = 1'b0;
        tb_last_port = 1;
        @(negedge clk);
        req_valid = 2'b11;
        #1;
        n_total++;
        if (req_ready !== 2'b01)
            $display("FAIL first_grant got=%b required=01", req_ready);
        else n_pass++;
        req_valid = 2'b00;
        #1;
        n_total++;
        if (req_ready !== 2'b00)
            $display("FAIL ready_idle got=%b required=00", req_ready);
        else n_pass++;
    endtask

    task automatic test_read_preload();
        logic got, err; int lat, nrd, nwr, ncs; logic [1:0] rv; logic [31:0] rd;
        run_txn(0, 1'b0, 32'h0000_1000, 32'h0, 4'h0, got, lat, rv, rd, err, nrd, nwr, ncs);
        n_total++;
        if (mem_addr !== 14'h0400 || mem_ba !== 3'd0)
            $display("FAIL read_addr got addr=%h ba=%h required 0400/0", mem_addr, mem_ba);
        else n_pass++;
        n_total++;
        if (rv !== 2'b01 || lat != 3)
            $display("FAIL read_latency got rv=%b lat=%0d required 01/3", rv, lat);
        else n_pass++;
        n_total++;
        if (rd !== 32'hDEADBEEF || err !== 1'b0)
            $display("FAIL read_data got %h err=%b required deadbeef/0", rd, err);
        else n_pass++;
    endtask

    task automatic test_full_write();
        logic got, err; int lat, nrd, nwr, ncs; logic [1:0] rv; logic [31:0] rd;
        logic [31:0] e_rd; logic e_err; int e_lat, e_nrd, e_nwr;
        ref_access(1'b1, 32'h10, 32'h12345678, 4'hF, e_rd, e_err, e_lat, e_nrd, e_nwr);
        run_txn(1, 1'b1, 32'h10, 32'h12345678, 4'hF, got, lat, rv, rd, err, nrd, nwr, ncs);
        n_total++;
        if (rv !== 2'b10 || lat != 2 || nwr != 1 || nrd != 0)
            $display("FAIL full_write got rv=%b lat=%0d wr=%0d rd=%0d required 10/2/1/0",
                     rv, lat, nwr, nrd);
        else n_pass++;
        run_txn(1, 1'b0, 32'h10, 32'h0, 4'h0, got, lat, rv, rd, err, nrd, nwr, ncs);
        n_total++;
        if (rd !== ref_word(32'h10) || rd !== 32'h12345678)
            $display("FAIL full_write_readback got %h required 12345678", rd);
        else n_pass++;
    endtask

    task automatic test_rmw();
        logic got, err; int lat, nrd, nwr, ncs; logic [1:0] rv; logic [31:0] rd;
        logic [31:0] e_rd; logic e_err; int e_lat, e_nrd, e_nwr;
        ref_access(1'b1, 32'h20, 32'h0000_1100, 4'b0010, e_rd, e_err, e_lat, e_nrd, e_nwr);
        run_txn(1, 1'b1, 32'h20, 32'h0000_1100, 4'b0010, got, lat, rv, rd, err, nrd, nwr, ncs);
        n_total++;
        if (lat != 5 || nrd != 1 || nwr != 1 || rd !== 32'h0)
            $display("FAIL rmw_seq got lat=%0d rd=%0d wr=%0d rdata=%h required 5/1/1/0",
                     lat, nrd, nwr, rd);
        else n_pass++;
        run_txn(0, 1'b0, 32'h20, 32'h0, 4'h0, got, lat, rv, rd, err, nrd, nwr, ncs);
        n_total++;
        if (rd !== 32'hAABB11DD)
            $display("FAIL rmw_readback got %h required aabb11dd", rd);
        else n_pass++;
        // zero strobe still goes through read/write and leaves the word intact
        run_txn(0, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'h0, got, lat, rv, rd, err, nrd, nwr, ncs);
        n_total++;
        if (lat != 5 || nrd != 1 || nwr != 1)
            $display("FAIL zero_strb_seq got lat=%0d rd=%0d wr=%0d required 5/1/1", lat, nrd, nwr);
        else n_pass++;
        run_txn(1, 1'b0, 32'h20, 32'h0, 4'h0, got, lat, rv, rd, err, nrd, nwr, ncs);
        n_total++;
        if (rd !== 32'hAABB11DD)
            $display("FAIL zero_strb_readback got %h required aabb11dd", rd);
        else n_pass++;
    endtask

    task automatic test_error();
        logic got, err; int lat, nrd, nwr, ncs; logic [1:0] rv; logic [31:0] rd;
        run_txn(0, 1'b0, 32'h0010_0000, 32'h0, 4'h0, got, lat, rv, rd, err, nrd, nwr, ncs);
        n_total++;
        if (err !== 1'b1 || rd !== 32'h0 || lat != 1 || rv !== 2'b01)
            $display("FAIL err_resp got err=%b rdata=%h lat=%0d rv=%b required 1/0/1/01",
                     err, rd, lat, rv);
        else n_pass++;
        n_total++;
        if (ncs != 0)
            $display("FAIL err_no_cmd got cs_low=%0d required 0", ncs);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic got, err; int lat, nrd, nwr, ncs; logic [1:0] rv; logic [31:0] rd;
        int k, pulses0;
        @(negedge clk);
        req_we[0] = 1'b0; req_addr[31:0] = 32'h0000_1000; req_valid[0] = 1'b1;
        #1;
        k = 0;
        while (!req_ready[0] && k < 50) begin
            @(negedge clk); #1; k++;
        end
        n_total++;
        if (!req_ready[0]) $display("FAIL midrst_accept got ready=%b required 1", req_ready[0]);
        else n_pass++;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        pulses0 = resp_pulses;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_total++;
        if ({mem_cs, mem_ras, mem_cas, mem_we} !== 4'b1111 || mem_dqs !== 1'b0 || resp_valid !== 2'b00)
            $display("FAIL midrst_pins got cmd=%b dqs=%b rv=%b required 1111/0/00",
                     {mem_cs, mem_ras, mem_cas, mem_we}, mem_dqs, resp_valid);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        tb_last_port = 1;
        repeat (5) @(negedge clk);
        n_total++;
        if (resp_pulses != pulses0)
            $display("FAIL midrst_no_resp got %0d pulses required 0", resp_pulses - pulses0);
        else n_pass++;
        run_txn(0, 1'b0, 32'h0000_1000, 32'h0, 4'h0, got, lat, rv, rd, err, nrd, nwr, ncs);
        n_total++;
        if (rd !== 32'hDEADBEEF || lat != 3 || rv !== 2'b01)
            $display("FAIL midrst_recover got rdata=%h lat=%0d rv=%b required deadbeef/3/01",
                     rd, lat, rv);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] a [2];
        logic [31:0] exp_data;
        int exp_port, prev, g, nacc, cyc, last_acc, pend;
        int cnt [2];
        prev = tb_last_port; nacc = 0; cyc = 0; last_acc = -1; pend = 0;
        cnt[0] = 0; cnt[1] = 0;
        exp_port = 0; exp_data = 32'h0;
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            a[p] = rand_addr();
            req_we[p] = 1'b0;
            req_addr[p*32 +: 32] = a[p];
        end
        req_valid = 2'b11;
        while ((nacc < 8 || pend != 0) && cyc < 300) begin
            #1;
            if (|resp_valid) begin
                n_total++;
                if (pend == 0 || resp_valid !== 2'(1 << exp_port) || resp_rdata !== exp_data)
                    $display("FAIL b2b_resp got rv=%b rdata=%h required port %0d data %h",
                             resp_valid, resp_rdata, exp_port, exp_data);
                else n_pass++;
                pend = 0;
            end
            if (|req_ready) begin
                g = req_ready[1] ? 1 : 0;
                n_total++;
                if (g == prev || req_ready == 2'b11)
                    $display("FAIL b2b_alternate got ready=%b required grant to port %0d",
                             req_ready, 1 - prev);
                else n_pass++;
                if (last_acc >= 0) begin
                    n_total++;
                    if (cyc - last_acc != 4)
                        $display("FAIL b2b_gap got %0d cycles required 4", cyc - last_acc);
                    else n_pass++;
                end
                last_acc = cyc;
                prev = g; cnt[g]++; nacc++;
                exp_port = g; exp_data = ref_word(a[g]); pend = 1;
                @(posedge clk); #1;
                if (nacc >= 8) begin
                    req_valid = 2'b00;
                end else begin
                    a[g] = rand_addr();
                    req_addr[g*32 +: 32] = a[g];
                end
            end
            @(negedge clk);
            cyc++;
        end
        req_valid = 2'b00;
        tb_last_port = prev;
        n_total++;
        if (cnt[0] != 4 || cnt[1] != 4)
            $display("FAIL b2b_fairness got p0=%0d p1=%0d required 4/4", cnt[0], cnt[1]);
        else n_pass++;
    endtask

    task automatic test_random();
        logic got, err; int lat, nrd, nwr, ncs; logic [1:0] rv; logic [31:0] rd;
        logic [31:0] e_rd; logic e_err; int e_lat, e_nrd, e_nwr;
        logic [31:0] a, wd; logic [3:0] strb; logic we; int p;
        for (int i = 0; i < 40; i++) begin
            p    = int'($urandom_range(0, 1));
            we   = 1'($urandom_range(0, 1));
            a    = rand_addr();
            if ($urandom_range(0, 7) == 0) a[19 + $urandom_range(0, 12)] = 1'b1;
            wd   = $urandom;
            strb = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            ref_access(we, a, wd, strb, e_rd, e_err, e_lat, e_nrd, e_nwr);
            run_txn(p, we, a, wd, strb, got, lat, rv, rd, err, nrd, nwr, ncs);
            if (got) begin
                n_total++;
                if (rd !== e_rd || err !== e_err || rv !== 2'(1 << p))
                    $display("FAIL rand_resp[%0d] we=%b addr=%h strb=%h got rdata=%h err=%b rv=%b required %h/%b/port %0d",
                             i, we, a, strb, rd, err, rv, e_rd, e_err, p);
                else n_pass++;
                n_total++;
                if (lat != e_lat || nrd != e_nrd || nwr != e_nwr)
                    $display("FAIL rand_timing[%0d] got lat=%0d rd=%0d wr=%0d required %0d/%0d/%0d",
                             i, lat, nrd, nwr, e_lat, e_nrd, e_nwr);
                else n_pass++;
            end
        end
        n_total++;
        if (bus_clash != 0)
            $display("FAIL dq_contention got %0d overlapping cycles required 0", bus_clash);
        else n_pass++;
        n_total++;
        if (mem_dm !== 4'h0)
            $display("FAIL dm_zero got %h required 0", mem_dm);
        else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        tb_oe = 1'b0;
        tb_dq = 32'h0;
        preload(32'h0000_1000, 32'hDEADBEEF);
        preload(32'h0000_0020, 32'hAABBCCDD);
        for (int i = 0; i < 32; i++) preload(32'h0003_0000 + 32'(i * 4), $urandom);
        test_reset();
        test_read_preload();
        test_full_write();
        test_rmw();
        test_error();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
